// File: rtl/dcache_responder_pkg.sv
// Shared encodings for the dcache responder: access sizes, ctrl bits, FSM state, VGA window.
package dcache_responder_pkg;

  localparam logic [1:0] WLEN_B = 2'b00;
  localparam logic [1:0] WLEN_H = 2'b01;
  localparam logic [1:0] WLEN_W = 2'b10;
  localparam logic [1:0] WLEN_D = 2'b11;

  localparam int CTRL_STALL = 0;
  localparam int CTRL_FLUSH = 1;

  localparam logic [31:0] VGA_BASE_DEF = 32'h2000_0000;
  localparam int          VGA_WIN_W    = 21;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_e;

  // A 32-bit bus has no dword access; treat it as a word.
  function automatic logic [1:0] eff_wlen(input logic [1:0] wlen, input int data_w);
    return (data_w == 32 && wlen == WLEN_D) ? WLEN_W : wlen;
  endfunction

endpackage

// File: rtl/dcache_lane_merge.sv
// Combinational byte-lane logic: store byte mask and read-modify-write merge, load extract.
module dcache_lane_merge
  import dcache_responder_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [1:0]                   wlen_i,
  input  logic [$clog2(DATA_W/8)-1:0]  lane_i,
  input  logic [DATA_W-1:0]            wdata_i,
  input  logic [DATA_W-1:0]            old_i,
  output logic [DATA_W/8-1:0]          mask_o,
  output logic [DATA_W-1:0]            merged_o,
  output logic [DATA_W-1:0]            load_o
);

  localparam int NB = DATA_W / 8;

  logic [NB-1:0]     size_mask;
  logic [DATA_W-1:0] wshift;
  logic [DATA_W-1:0] oshift;

  always_comb begin
    size_mask = '0;
    for (int b = 0; b < NB; b++) size_mask[b] = (b < (1 << wlen_i));
  end

  assign mask_o = size_mask << lane_i;
  assign wshift = wdata_i << {lane_i, 3'b000};
  assign oshift = old_i >> {lane_i, 3'b000};

  for (genvar b = 0; b < NB; b++) begin : g_byte
    assign merged_o[8*b +: 8] = mask_o[b]    ? wshift[8*b +: 8] : old_i[8*b +: 8];
    assign load_o[8*b +: 8]   = size_mask[b] ? oshift[8*b +: 8] : 8'h00;
  end

endmodule

// File: rtl/dcache_responder.sv
// Fixed-latency memory responder for the core's dcache port, backed by a word RAM.
// Define DCACHE_RESP_VGA_EN to map stores in [VGA_BASE, VGA_BASE+2^21) onto the framebuffer port.
module dcache_responder
  import dcache_responder_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 64,
  parameter int                DEPTH    = 4096,
  parameter int                LAT      = 2,
  parameter int                CTRL_W   = 2,
  parameter logic [ADDR_W-1:0] VGA_BASE = ADDR_W'(VGA_BASE_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dcache_req_valid_i,
  input  logic              dcache_wen_i,
  input  logic [ADDR_W-1:0] dcache_addr_i,
  input  logic [DATA_W-1:0] dcache_wdata_i,
  input  logic [1:0]        dcache_wlen_i,
  input  logic [CTRL_W-1:0] dcache_ctrl_signal_i,
  output logic              dcache_ready_o,
  output logic              dcache_data_valid_o,
  output logic [DATA_W-1:0] dcache_data_o,
  output logic [9:0]        vga_waddr_h_o,
  output logic [8:0]        vga_waddr_v_o,
  output logic              vga_we_o,
  output logic [23:0]       vga_wdata_o
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
`ifdef DCACHE_RESP_VGA_EN
  localparam bit VGA_EN = 1'b1;
`else
  localparam bit VGA_EN = 1'b0;
`endif

  state_e state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        wlen_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] data_q;
  logic              vga_we_q;
  logic [9:0]        vga_h_q;
  logic [8:0]        vga_v_q;
  logic [23:0]       vga_px_q;

  logic              stall, flush, accept, commit;
  logic [1:0]        wlen_eff;
  logic [ADDR_W-1:0] addr_al;
  logic [OFF_W-1:0]  lane;
  logic [IDX_W-1:0]  idx;
  logic              in_ram, in_vga;
  logic [ADDR_W:0]   vga_off;
  logic [NB-1:0]     mask;
  logic [DATA_W-1:0] merged, load_word;

  assign stall = dcache_ctrl_signal_i[CTRL_STALL];
  assign flush = dcache_ctrl_signal_i[CTRL_FLUSH];

  // Decode from the latched request, after forcing sub-size address bits to zero.
  assign wlen_eff = eff_wlen(wlen_q, DATA_W);
  assign addr_al  = addr_q & ~ADDR_W'((32'd1 << wlen_eff) - 32'd1);
  assign lane     = addr_al[OFF_W-1:0];
  assign idx      = addr_al[OFF_W +: IDX_W];
  assign in_ram   = ((addr_al >> (OFF_W + IDX_W)) == '0) && (int'(idx) < DEPTH);
  assign vga_off  = {1'b0, addr_al} - {1'b0, VGA_BASE};
  assign in_vga   = VGA_EN && !in_ram && !vga_off[ADDR_W] &&
                    ((vga_off[ADDR_W-1:0] >> VGA_WIN_W) == '0);

  dcache_lane_merge #(.DATA_W(DATA_W)) u_merge (
    .wlen_i   (wlen_eff),
    .lane_i   (lane),
    .wdata_i  (wdata_q),
    .old_i    (mem_q[idx]),
    .mask_o   (mask),
    .merged_o (merged),
    .load_o   (load_word)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (dcache_req_valid_i) state_d = ST_BUSY;
      ST_BUSY: begin
        if (flush)             state_d = ST_IDLE;
        else if (cnt_q == '0)  state_d = ST_RESP;
      end
      ST_RESP: if (!stall)     state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dcache_ready_o      = (state_q == ST_IDLE);
    dcache_data_valid_o = (state_q == ST_RESP);
  end

  assign accept = (state_q == ST_IDLE) && dcache_req_valid_i;
  assign commit = (state_q == ST_BUSY) && !flush && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wlen_q   <= WLEN_B;
      data_q   <= '0;
      vga_we_q <= 1'b0;
      vga_h_q  <= '0;
      vga_v_q  <= '0;
      vga_px_q <= '0;
    end else begin
      vga_we_q <= 1'b0;
      if (accept) begin
        wen_q   <= dcache_wen_i;
        addr_q  <= dcache_addr_i;
        wdata_q <= dcache_wdata_i;
        wlen_q  <= dcache_wlen_i;
        cnt_q   <= CNT_W'(LAT - 1);
      end else if (state_q == ST_BUSY && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (commit) begin
        data_q <= (!wen_q && in_ram) ? load_word : '0;
        if (wen_q && in_vga) begin
          vga_we_q <= 1'b1;
          vga_h_q  <= addr_al[11:2];
          vga_v_q  <= addr_al[20:12];
          vga_px_q <= wdata_q[23:0];
        end
      end
    end
  end

  // RAM is not reset; a reset in flight simply suppresses the commit.
  always_ff @(posedge clk) begin
    if (!rst && commit && wen_q && in_ram && (mask != '0)) mem_q[idx] <= merged;
  end

  assign dcache_data_o = data_q;
  assign vga_we_o      = vga_we_q;
  assign vga_waddr_h_o = vga_h_q;
  assign vga_waddr_v_o = vga_v_q;
  assign vga_wdata_o   = vga_px_q;

endmodule

// File: tb/tb_dcache_responder.sv
// Randomized bench for dcache_responder against a byte-addressed reference memory.
module tb_dcache_responder;

  localparam int          ADDR_W   = 32;
  localparam int          DATA_W   = 64;
  localparam int          DEPTH    = 4096;
  localparam int          LAT      = 2;
  localparam int          RAM_B    = DEPTH * 8;
  localparam logic [31:0] VGA_BASE = 32'h2000_0000;
`ifdef DCACHE_RESP_VGA_EN
  localparam bit VGA_EN = 1'b1;
`else
  localparam bit VGA_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              wen = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [1:0]        wlen = 2'b00;
  logic [1:0]        ctrl = 2'b00;
  logic              ready, dvalid, vga_we;
  logic [DATA_W-1:0] rdata;
  logic [9:0]        vga_h;
  logic [8:0]        vga_v;
  logic [23:0]       vga_px;

  int total = 0;
  int bad   = 0;
  logic [7:0] mdl [RAM_B];

  dcache_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .LAT(LAT), .CTRL_W(2), .VGA_BASE(VGA_BASE)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .dcache_req_valid_i   (req_valid),
    .dcache_wen_i         (wen),
    .dcache_addr_i        (addr),
    .dcache_wdata_i       (wdata),
    .dcache_wlen_i        (wlen),
    .dcache_ctrl_signal_i (ctrl),
    .dcache_ready_o       (ready),
    .dcache_data_valid_o  (dvalid),
    .dcache_data_o        (rdata),
    .vga_waddr_h_o        (vga_h),
    .vga_waddr_v_o        (vga_v),
    .vga_we_o             (vga_we),
    .vga_wdata_o          (vga_px)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // abort: 0 none, 1 flush, 2 reset, 3 flush+stall together
  task automatic run_req(input bit w, input logic [31:0] a_in, input logic [63:0] wd,
                         input logic [1:0] wl, input int nstall, input int abort);
    int          n, waits;
    logic [31:0] a;
    logic [63:0] exp;
    bit          in_ram, in_vga;
    n      = 1 << wl;
    a      = a_in & ~(n - 1);
    in_ram = (a < RAM_B);
    in_vga = VGA_EN && (a >= VGA_BASE) && (a < VGA_BASE + (32'd1 << 21));
    exp    = '0;
    if (!w && in_ram)
      for (int b = 0; b < n; b++) exp[8*b +: 8] = mdl[a + b];
    waits = 0;
    @(negedge clk);
    while (!ready && waits < 20) begin @(negedge clk); waits++; end
    chk("ready_before_req", ready, 1);
    req_valid = 1'b1; wen = w; addr = a_in; wdata = wd; wlen = wl;
    @(negedge clk);
    req_valid = 1'b0;
    chk("busy_ready", ready, 0);
    chk("busy_valid", dvalid, 0);
    if (abort == 1 || abort == 3 || abort == 2) begin
      if (abort == 2) rst = 1'b1;
      else ctrl = (abort == 3) ? 2'b11 : 2'b10;
      @(negedge clk);
      rst = 1'b0; ctrl = 2'b00;
      chk("abort_ready", ready, 1);
      chk("abort_valid", dvalid, 0);
      @(negedge clk);
      chk("abort_no_pulse", dvalid, 0);
      return;
    end
    for (int k = 1; k < LAT; k++) begin
      @(negedge clk);
      chk("lat_valid_low", dvalid, 0);
      chk("lat_ready_low", ready, 0);
    end
    @(negedge clk);
    for (int j = 0; j <= nstall; j++) begin
      chk("resp_valid", dvalid, 1);
      chk("resp_ready", ready, 0);
      chk("resp_data", rdata, exp);
      chk("vga_we", vga_we, (j == 0) && w && in_vga);
      if (j == 0 && w && in_vga) begin
        chk("vga_h", vga_h, a[11:2]);
        chk("vga_v", vga_v, a[20:12]);
        chk("vga_px", vga_px, wd[23:0]);
      end
      ctrl = (j < nstall) ? 2'b01 : 2'b00;
      @(negedge clk);
    end
    ctrl = 2'b00;
    chk("post_valid", dvalid, 0);
    chk("post_ready", ready, 1);
    if (w && in_ram)
      for (int b = 0; b < n; b++) mdl[a + b] = wd[8*b +: 8];
  endtask

  initial begin
    logic [31:0] ra;
    logic [63:0] rd;
    fork
      begin
        #2_000_000;
        $display("FAIL timeout got=running exp=done");
        $fatal(1, "timeout");
      end
    join_none

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_valid", dvalid, 0);
    chk("rst_data", rdata, 0);
    chk("rst_vga_we", vga_we, 0);
    chk("rst_vga_h", vga_h, 0);
    chk("rst_vga_v", vga_v, 0);
    chk("rst_vga_px", vga_px, 0);

    for (int i = 0; i < 32; i++)
      run_req(1, 32'(i * 8), {$urandom, $urandom}, 2'b11, 0, 0);
    run_req(1, 32'h5018, 64'hCAFE_F00D_DEAD_BEEF, 2'b11, 0, 0);

    run_req(1, 32'h10, 64'h1122_3344_5566_7788, 2'b11, 0, 0);
    run_req(0, 32'h10, 64'h0, 2'b11, 0, 0);
    run_req(1, 32'h13, 64'hFFFF_FFFF_FFFF_FFAB, 2'b00, 0, 0);
    run_req(0, 32'h10, 64'h0, 2'b10, 0, 0);
    run_req(0, 32'h16, 64'h0, 2'b01, 0, 0);

    run_req(1, 32'h20, 64'h0BAD_0BAD_0BAD_0BAD, 2'b11, 0, 1);
    run_req(0, 32'h20, 64'h0, 2'b11, 0, 0);
    run_req(1, 32'h20, 64'h0BAD_0BAD_0BAD_0BAD, 2'b11, 0, 2);
    run_req(0, 32'h20, 64'h0, 2'b11, 0, 0);
    run_req(1, 32'h20, 64'h0BAD_0BAD_0BAD_0BAD, 2'b11, 0, 3);
    run_req(0, 32'h20, 64'h0, 2'b11, 0, 0);

    run_req(0, 32'h10, 64'h0, 2'b11, 2, 0);

    run_req(0, 32'(RAM_B), 64'h0, 2'b11, 0, 0);
    run_req(1, 32'(RAM_B), 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 0, 0);
    run_req(0, 32'h0, 64'h0, 2'b11, 0, 0);

    run_req(1, VGA_BASE + (32'd5 << 12) + (32'd7 << 2), 64'h0000_0000_00FF_8000, 2'b10, 0, 0);
    run_req(0, VGA_BASE + (32'd5 << 12) + (32'd7 << 2), 64'h0, 2'b10, 0, 0);
    run_req(0, 32'h5018, 64'h0, 2'b11, 0, 0);

    for (int i = 0; i < 150; i++) begin
      ra = ($urandom_range(0, 9) == 0) ? 32'(RAM_B + $urandom_range(0, 4095)) : 32'($urandom_range(0, 255));
      rd = {$urandom, $urandom};
      run_req(1'($urandom_range(0, 1)), ra, rd, 2'($urandom_range(0, 3)),
              $urandom_range(0, 2), ($urandom_range(0, 11) == 0) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
